uart_loop_bist: RTL and testbench
=================================

# uart_loop_bist

Built-in self-test sequencer for the UART loopback datapath: drives the transmitter's tx_en/tx_din, enables the receiver, and checks every received byte against an LFSR-generated expected value. It sits beside the uart_tx/uart_recv loopback pair and replaces external stimulus during board bring-up. It reports a pass/fail flag and a saturating error count.

## Interface
- CLK_FREQ, 50000000, system clock frequency in Hz
- UART_BPS, 115200, line rate; sets the per-byte timeout
- NUM_BYTES, 16, bytes per test run (1..256)
- sys_clk  in  1  system clock, rising edge
- sys_rst_n  in  1  reset; one clock, asynchronous, active-low
- start  in  1  one-cycle pulse; starts a run (honoured only in IDLE)
- abort  in  1  level; cancels a run in progress
- seed  in  8  LFSR seed, sampled on accepted start
- tx_en  out  1  one-cycle transmit strobe to uart_tx
- tx_din  out  8  transmit byte, valid while tx_en=1
- tx_busy  in  1  transmitter busy
- rec_en  out  1  receiver enable (level)
- rec_dout  in  8  received byte, valid when rec_busy falls
- rec_busy  in  1  receiver busy during frame reception
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run completion
- pass  out  1  level; 1 = last run finished with err_cnt==0
- err_cnt  out  8  mismatches plus timeouts in current/last run, saturates at 255

## Operation
- Pattern: 8-bit Fibonacci LFSR, fb = b7^b5^b4^b3, next = {lfsr[6:0], fb}. A seed of 0x00 is replaced by 0x01. Byte k = LFSR after k steps (byte 0 = seed).
- Per-byte timeout: TO_CYC = 24*(CLK_FREQ/UART_BPS) cycles (10416 at defaults), counted from SEND.
- IDLE: busy=0, rec_en=0.
  - On start: load lfsr, idx=0, err_cnt=0, pass=0, busy=1, rec_en=1, then go to ARM.
- ARM: wait until tx_busy=0 and rec_busy=0, then go to SEND.
- SEND: tx_en=1 for exactly one cycle with tx_din=lfsr. Latch expected=lfsr, clear the timeout counter and seen_rx, then go to WAIT_RX.
- WAIT_RX:
  - Set seen_rx when rec_busy=1.
  - When seen_rx=1 and rec_busy=0, go to CHECK.
  - When the timeout counter reaches TO_CYC-1 first, err_cnt++ (saturating) and go to NEXT.
- CHECK: if rec_dout != expected, err_cnt++ (saturating). Go to NEXT.
- NEXT: if idx==NUM_BYTES-1, go to DONE. Otherwise idx++, lfsr advances one step, and go to ARM.
- DONE: done=1 for one cycle, pass=(err_cnt==0), busy=0, rec_en=0, then go to IDLE.
- abort=1 in any non-IDLE state: next cycle is IDLE with busy=0, rec_en=0, pass=0. done is not pulsed; err_cnt is held.
- start while busy=1 is ignored. start and abort asserted together in IDLE: start wins and abort is ignored for that cycle.
- err_cnt and pass hold their values after DONE until the next accepted start.

## Timing
- Reset values: tx_en=0, tx_din=0x00, rec_en=0, busy=0, done=0, pass=0, err_cnt=0, state=IDLE.
- All outputs are registered.
- Accepted start → busy=1 and rec_en=1 on the next edge.
- First tx_en occurs no earlier than 2 cycles after start (ARM then SEND).
- tx_en is high for exactly one cycle per byte; tx_din changes only in SEND and is held until the next SEND.
- The rec_busy falling edge is detected one cycle late (registered). CHECK samples rec_dout in the cycle after the fall; the receiver holds rec_dout until its next frame.
- CHECK → ARM takes 2 cycles (via NEXT).
- done is asserted in the same cycle busy drops to 0; pass is valid from that cycle.
- Exactly NUM_BYTES tx_en pulses per un-aborted run.

## Test plan
- Loopback, seed=0x01, NUM_BYTES=5 → tx_din sequence 0x01,0x02,0x04,0x08,0x11; done pulse; pass=1; err_cnt=0.
- Model forces rec_dout bit0 inverted on byte 2 only → err_cnt=1, pass=0 at done.
- Receiver model never raises rec_busy, NUM_BYTES=3 → each byte times out after 10416 cycles; err_cnt=3, pass=0, 3 tx_en pulses.
- seed=0x00 → first tx_din=0x01; start pulsed again mid-run → ignored, tx_en count still NUM_BYTES.
- abort during byte 3 of 16 → busy=0 and rec_en=0 next cycle, no done, pass=0; a subsequent start completes normally.
- sys_rst_n asserted mid-WAIT_RX → all outputs at reset values immediately; err_cnt=0; no tx_en until a new start.

Source files
------------

// File: rtl/uart_loop_bist_if.sv
// ---------------------------------------------------------------------------
// uart_loop_bist_if
//   Connection between the BIST sequencer and the uart_tx/uart_recv loopback
//   pair.
//
//   tx_en    : one-cycle transmit strobe (sequencer -> uart_tx)
//   tx_din   : byte to transmit, valid while tx_en=1
//   tx_busy  : transmitter busy (uart_tx -> sequencer)
//   rec_en   : receiver enable level (sequencer -> uart_recv)
//   rec_dout : received byte, valid once rec_busy falls
//   rec_busy : receiver busy during frame reception
//
//   master : sequencer side
//   slave  : UART pair side
// ---------------------------------------------------------------------------
interface uart_loop_bist_if;
  logic       tx_en;
  logic [7:0] tx_din;
  logic       tx_busy;
  logic       rec_en;
  logic [7:0] rec_dout;
  logic       rec_busy;

  modport master (
    output tx_en, tx_din, rec_en,
    input  tx_busy, rec_dout, rec_busy
  );

  modport slave (
    input  tx_en, tx_din, rec_en,
    output tx_busy, rec_dout, rec_busy
  );
endinterface

// File: rtl/uart_loop_bist.sv
// ---------------------------------------------------------------------------
// uart_loop_bist
//   Built-in self-test sequencer for the UART loopback datapath. Sends
//   NUM_BYTES LFSR-generated bytes through uart_tx, waits for each to come
//   back through uart_recv, and counts mismatches and per-byte timeouts.
//
//   Parameters:
//     CLK_FREQ  : system clock frequency in Hz
//     UART_BPS  : line rate; sets the per-byte timeout
//     NUM_BYTES : bytes per test run (1..256)
//
//   Ports:
//     sys_clk   : system clock, rising edge
//     sys_rst_n : asynchronous active-low reset
//     start     : one-cycle pulse, starts a run (honoured only when idle)
//     abort     : level, cancels a run in progress
//     seed      : LFSR seed, sampled on an accepted start
//     uart      : tx/rx handshake to the loopback pair (master side)
//     busy      : run in progress
//     done      : one-cycle pulse at run completion
//     pass      : last run finished with err_cnt == 0
//     err_cnt   : mismatches plus timeouts, saturating at 255
// ---------------------------------------------------------------------------
module uart_loop_bist #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 115200,
  parameter int NUM_BYTES = 16
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       seed,
  uart_loop_bist_if.master uart,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_cnt
);

  // A frame is 10 bit times; allowing 24 leaves room for a slow receiver
  // and the arm/check overhead without masking a dead loopback.
  localparam int TO_CYC = 24 * (CLK_FREQ / UART_BPS);
  localparam int TO_W   = $clog2(TO_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SEND,
    S_WAIT_RX,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [7:0]      lfsr;
  logic [7:0]      expected;
  logic [7:0]      idx;
  logic [TO_W-1:0] to_cnt;
  logic            seen_rx;
  logic            err_inc;

  // seen_rx is registered, so the fall of rec_busy is recognised one cycle
  // after it happens; rec_dout is stable by then.
  logic rx_fall;
  logic timeout;
  logic last_byte;

  assign rx_fall   = seen_rx && !uart.rec_busy;
  assign timeout   = (to_cnt == TO_W'(TO_CYC - 1));
  assign last_byte = (idx == 8'(NUM_BYTES - 1));

  // Fibonacci LFSR, taps 8,6,5,4.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values of its neighbours.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= S_IDLE;
    else            state <= next_state;
  end

  // NOTE: every output of this block is given a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    err_inc    = 1'b0;
    case (state)
      S_IDLE:    if (start) next_state = S_ARM;
      S_ARM:     if (!uart.tx_busy && !uart.rec_busy) next_state = S_SEND;
      S_SEND:    next_state = S_WAIT_RX;
      S_WAIT_RX: begin
        if (rx_fall) begin
          next_state = S_CHECK;
        end else if (timeout) begin
          next_state = S_NEXT;
          err_inc    = 1'b1;
        end
      end
      S_CHECK: begin
        next_state = S_NEXT;
        err_inc    = (uart.rec_dout != expected);
      end
      S_NEXT:    next_state = last_byte ? S_DONE : S_ARM;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase

    // Abort beats everything except a start seen in IDLE; the error count
    // is frozen at its current value.
    if (abort && state != S_IDLE) begin
      next_state = S_IDLE;
      err_inc    = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      uart.tx_en  <= 1'b0;
      uart.tx_din <= 8'h00;
      uart.rec_en <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      err_cnt     <= 8'h00;
      lfsr        <= 8'h01;
      expected    <= 8'h00;
      idx         <= 8'h00;
      to_cnt      <= '0;
      seen_rx     <= 1'b0;
    end else begin
      uart.tx_en <= 1'b0;
      done       <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            // An all-zero seed would lock the LFSR at zero.
            lfsr        <= (seed == 8'h00) ? 8'h01 : seed;
            idx         <= 8'h00;
            err_cnt     <= 8'h00;
            pass        <= 1'b0;
            busy        <= 1'b1;
            uart.rec_en <= 1'b1;
          end
        end
        S_ARM: begin
          // Outputs are registered, so the SEND-state strobe is loaded on
          // the edge that enters SEND.
          if (next_state == S_SEND) begin
            uart.tx_en  <= 1'b1;
            uart.tx_din <= lfsr;
            expected    <= lfsr;
            to_cnt      <= '0;
            seen_rx     <= 1'b0;
          end
        end
        S_WAIT_RX: begin
          to_cnt <= to_cnt + TO_W'(1);
          if (uart.rec_busy) seen_rx <= 1'b1;
        end
        S_NEXT: begin
          if (next_state == S_ARM) begin
            idx  <= idx + 8'd1;
            lfsr <= lfsr_step(lfsr);
          end else if (next_state == S_DONE) begin
            done        <= 1'b1;
            pass        <= (err_cnt == 8'h00);
            busy        <= 1'b0;
            uart.rec_en <= 1'b0;
          end
        end
        default: ;
      endcase

      if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

      if (abort && state != S_IDLE) begin
        busy        <= 1'b0;
        uart.rec_en <= 1'b0;
        pass        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_loop_bist.sv
// ---------------------------------------------------------------------------
// tb_uart_loop_bist
//   dut_a (NUM_BYTES=5) runs against a behavioural loopback model that can
//   corrupt one chosen byte. dut_b (NUM_BYTES=3) sees a receiver that never
//   answers, so every byte times out. Stimulus pushes expected tx bytes and
//   expected {busy,pass,err_cnt} at done into queues; monitors pop and
//   compare whenever the DUTs present tx_en or done.
// ---------------------------------------------------------------------------
module tb_uart_loop_bist;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- dut_a: loopback ----------------
  logic       start_a = 1'b0;
  logic       abort_a = 1'b0;
  logic [7:0] seed_a  = 8'h00;
  logic       busy_a, done_a, pass_a;
  logic [7:0] err_a;

  logic       tx_busy_m  = 1'b0;
  logic       rec_busy_m = 1'b0;
  logic [7:0] rec_dout_m = 8'h00;

  uart_loop_bist_if if_a ();
  assign if_a.tx_busy  = tx_busy_m;
  assign if_a.rec_busy = rec_busy_m;
  assign if_a.rec_dout = rec_dout_m;

  uart_loop_bist #(.NUM_BYTES(5)) dut_a (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start_a),
    .abort     (abort_a),
    .seed      (seed_a),
    .uart      (if_a.master),
    .busy      (busy_a),
    .done      (done_a),
    .pass      (pass_a),
    .err_cnt   (err_a)
  );

  // Loopback model: tx_busy for 20 cycles, rec_busy from cycle 4 to 17,
  // rec_dout updated as rec_busy falls. One byte value can be corrupted.
  logic       corrupt_en  = 1'b0;
  logic [7:0] corrupt_val = 8'h00;
  logic [7:0] frame_byte  = 8'h00;
  int         frame_cnt   = 0;

  always @(negedge sys_clk) begin
    if (if_a.tx_en) begin
      frame_byte <= if_a.tx_din ^ ((corrupt_en && if_a.tx_din == corrupt_val) ? 8'h01 : 8'h00);
      frame_cnt  <= 1;
      tx_busy_m  <= 1'b1;
    end else if (frame_cnt > 0) begin
      frame_cnt <= frame_cnt + 1;
      if (frame_cnt == 4) rec_busy_m <= 1'b1;
      if (frame_cnt == 18) begin
        rec_busy_m <= 1'b0;
        rec_dout_m <= frame_byte;
      end
      if (frame_cnt == 20) begin
        tx_busy_m <= 1'b0;
        frame_cnt <= 0;
      end
    end
  end

  logic [7:0] tx_q_a[$];
  logic [9:0] done_q_a[$];
  int         tx_seen_a   = 0;
  int         done_seen_a = 0;

  always @(negedge sys_clk) begin
    logic [8:0] etx;
    logic [9:0] edn;
    if (sys_rst_n) begin
      if (if_a.tx_en) begin
        etx = (tx_q_a.size() > 0) ? {1'b0, tx_q_a.pop_front()} : 9'h100;
        check("tx_din_a", 32'({1'b0, if_a.tx_din}), 32'(etx));
        tx_seen_a <= tx_seen_a + 1;
      end
      if (done_a) begin
        edn = (done_q_a.size() > 0) ? done_q_a.pop_front() : 10'h3FF;
        check("done_busy_pass_err_a", 32'({busy_a, pass_a, err_a}), 32'(edn));
        done_seen_a <= done_seen_a + 1;
      end
    end
  end

  // ---------------- dut_b: silent receiver ----------------
  logic       start_b = 1'b0;
  logic       abort_b = 1'b0;
  logic [7:0] seed_b  = 8'h00;
  logic       busy_b, done_b, pass_b;
  logic [7:0] err_b;

  uart_loop_bist_if if_b ();
  assign if_b.tx_busy  = 1'b0;
  assign if_b.rec_busy = 1'b0;
  assign if_b.rec_dout = 8'h00;

  uart_loop_bist #(.NUM_BYTES(3)) dut_b (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start_b),
    .abort     (abort_b),
    .seed      (seed_b),
    .uart      (if_b.master),
    .busy      (busy_b),
    .done      (done_b),
    .pass      (pass_b),
    .err_cnt   (err_b)
  );

  logic [7:0] tx_q_b[$];
  logic [9:0] done_q_b[$];
  int         tx_seen_b   = 0;
  int         done_seen_b = 0;
  int         last_tx_b   = 0;

  // Timeout path: SEND, TO_CYC WAIT_RX cycles, NEXT, ARM, SEND
  // -> tx_en period 10416 + 3 = 10419 cycles.
  always @(negedge sys_clk) begin
    logic [8:0] etx;
    logic [9:0] edn;
    if (sys_rst_n) begin
      if (if_b.tx_en) begin
        etx = (tx_q_b.size() > 0) ? {1'b0, tx_q_b.pop_front()} : 9'h100;
        check("tx_din_b", 32'({1'b0, if_b.tx_din}), 32'(etx));
        if (tx_seen_b > 0) check("timeout_spacing_b", cyc - last_tx_b, 10419);
        last_tx_b <= cyc;
        tx_seen_b <= tx_seen_b + 1;
      end
      if (done_b) begin
        edn = (done_q_b.size() > 0) ? done_q_b.pop_front() : 10'h3FF;
        check("done_busy_pass_err_b", 32'({busy_b, pass_b, err_b}), 32'(edn));
        done_seen_b <= done_seen_b + 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push_seq(input logic [7:0] b0, b1, b2, b3, b4, input int n);
    logic [7:0] v[5];
    v = '{b0, b1, b2, b3, b4};
    for (int i = 0; i < n; i++) tx_q_a.push_back(v[i]);
  endtask

  task automatic pulse_start_a(input logic [7:0] s, input logic with_abort);
    @(posedge sys_clk); #1;
    start_a = 1'b1;
    seed_a  = s;
    abort_a = with_abort;
    @(posedge sys_clk); #1;
    start_a = 1'b0;
    abort_a = 1'b0;
  endtask

  task automatic wait_tx_a(input int target, input int budget);
    int n = 0;
    while (tx_seen_a < target && n < budget) begin
      tick(1);
      n++;
    end
    check("wait_tx_a", 32'(tx_seen_a >= target), 32'd1);
  endtask

  task automatic wait_done_a(input int base, input int budget);
    int n = 0;
    while (done_seen_a == base && n < budget) begin
      tick(1);
      n++;
    end
    check("wait_done_a", 32'(done_seen_a == base + 1), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;

    tick(3);
    check("rst_tx_en",   32'(if_a.tx_en),  32'd0);
    check("rst_tx_din",  32'(if_a.tx_din), 32'h00);
    check("rst_rec_en",  32'(if_a.rec_en), 32'd0);
    check("rst_busy",    32'(busy_a),      32'd0);
    check("rst_done",    32'(done_a),      32'd0);
    check("rst_pass",    32'(pass_a),      32'd0);
    check("rst_err_cnt", 32'(err_a),       32'd0);
    sys_rst_n = 1'b1;
    tick(5);

    // Clean loopback, seed 0x01.
    push_seq(8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 5);
    done_q_a.push_back({1'b0, 1'b1, 8'd0});
    base = done_seen_a;
    pulse_start_a(8'h01, 1'b0);
    check("start_busy",   32'(busy_a),      32'd1);
    check("start_rec_en", 32'(if_a.rec_en), 32'd1);
    check("arm_no_tx_en", 32'(if_a.tx_en),  32'd0);
    tick(1);
    check("first_tx_en",  32'(if_a.tx_en),  32'd1);
    wait_done_a(base, 2000);
    tick(10);
    check("pass_held",   32'(pass_a),      32'd1);
    check("rec_en_off",  32'(if_a.rec_en), 32'd0);
    check("tx_q_a_empty_1", 32'(tx_q_a.size()), 32'd0);

    // Corrupt byte 2 (0x04) -> one mismatch.
    corrupt_en  = 1'b1;
    corrupt_val = 8'h04;
    push_seq(8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 5);
    done_q_a.push_back({1'b0, 1'b0, 8'd1});
    base = done_seen_a;
    pulse_start_a(8'h01, 1'b0);
    wait_done_a(base, 2000);
    corrupt_en = 1'b0;
    tick(10);
    check("err_held_after_done", 32'(err_a), 32'd1);
    check("pass_low_after_err",  32'(pass_a), 32'd0);

    // Zero seed maps to 0x01; a second start mid-run is ignored.
    push_seq(8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 5);
    done_q_a.push_back({1'b0, 1'b1, 8'd0});
    base = done_seen_a;
    check("clear_on_start_pre", 32'(err_a), 32'd1);
    pulse_start_a(8'h00, 1'b0);
    check("err_cleared_on_start", 32'(err_a), 32'd0);
    wait_tx_a(tx_seen_a + 1, 200);
    pulse_start_a(8'h55, 1'b0);
    wait_done_a(base, 2000);
    tick(30);
    check("tx_q_a_empty_2", 32'(tx_q_a.size()), 32'd0);

    // Abort during byte 3 with one earlier mismatch on 0x4A.
    corrupt_en  = 1'b1;
    corrupt_val = 8'h4A;
    push_seq(8'hA5, 8'h4A, 8'h95, 8'h00, 8'h00, 3);
    base = done_seen_a;
    pulse_start_a(8'hA5, 1'b0);
    wait_tx_a(tx_seen_a + 3, 500);
    tick(3);
    abort_a = 1'b1;
    tick(1);
    abort_a = 1'b0;
    check("abort_busy",   32'(busy_a),      32'd0);
    check("abort_rec_en", 32'(if_a.rec_en), 32'd0);
    check("abort_pass",   32'(pass_a),      32'd0);
    check("abort_err_held", 32'(err_a),     32'd1);
    corrupt_en = 1'b0;
    tick(40);
    check("abort_no_done", 32'(done_seen_a - base), 32'd0);
    check("tx_q_a_empty_3", 32'(tx_q_a.size()), 32'd0);

    // start and abort together in IDLE: start wins; run completes.
    push_seq(8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 5);
    done_q_a.push_back({1'b0, 1'b1, 8'd0});
    base = done_seen_a;
    pulse_start_a(8'h01, 1'b1);
    check("start_beats_abort", 32'(busy_a), 32'd1);
    wait_done_a(base, 2000);
    tick(30);

    // Reset during WAIT_RX of byte 1, after a mismatch on byte 0.
    corrupt_en  = 1'b1;
    corrupt_val = 8'h01;
    push_seq(8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 2);
    pulse_start_a(8'h01, 1'b0);
    wait_tx_a(tx_seen_a + 2, 500);
    tick(3);
    check("pre_reset_err", 32'(err_a), 32'd1);
    #3 sys_rst_n = 1'b0;
    #1;
    check("mid_rst_tx_en",  32'(if_a.tx_en),  32'd0);
    check("mid_rst_tx_din", 32'(if_a.tx_din), 32'h00);
    check("mid_rst_rec_en", 32'(if_a.rec_en), 32'd0);
    check("mid_rst_busy",   32'(busy_a),      32'd0);
    check("mid_rst_done",   32'(done_a),      32'd0);
    check("mid_rst_pass",   32'(pass_a),      32'd0);
    check("mid_rst_err",    32'(err_a),       32'd0);
    corrupt_en = 1'b0;
    tick(1);
    sys_rst_n = 1'b1;
    base = tx_seen_a;
    tick(60);
    check("no_tx_after_reset", 32'(tx_seen_a - base), 32'd0);
    check("tx_q_a_empty_4",    32'(tx_q_a.size()),    32'd0);
    check("done_q_a_empty",    32'(done_q_a.size()),  32'd0);

    // dut_b: receiver never answers -> three timeouts.
    tx_q_b.push_back(8'h01);
    tx_q_b.push_back(8'h02);
    tx_q_b.push_back(8'h04);
    done_q_b.push_back({1'b0, 1'b0, 8'd3});
    @(posedge sys_clk); #1;
    start_b = 1'b1;
    seed_b  = 8'h01;
    tick(1);
    start_b = 1'b0;
    begin
      int n = 0;
      while (done_seen_b == 0 && n < 40000) begin
        tick(1);
        n++;
      end
    end
    check("wait_done_b",   32'(done_seen_b), 32'd1);
    check("tx_count_b",    32'(tx_seen_b),   32'd3);
    check("tx_q_b_empty",  32'(tx_q_b.size()),   32'd0);
    check("done_q_b_empty", 32'(done_q_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
